// File: rtl/alu_op_sequencer_if.sv
// Command/result bundle for alu_op_sequencer: command handshake in, result/status handshake out.
// Sticky status signals exist only when ALU_SEQ_STICKY_EN is defined.
interface alu_op_sequencer_if #(
  parameter int m = 4,
  parameter int n = 2
);
  logic         i_valid;
  logic         o_ready;
  logic [n-1:0] i_op;
  logic [m-1:0] i_argA;
  logic [m-1:0] i_argB;
  logic         o_valid;
  logic         i_ready;
  logic [m-1:0] o_result;
  logic [3:0]   o_status;
`ifdef ALU_SEQ_STICKY_EN
  logic [3:0]   o_sticky;
  logic         i_sticky_clr;

  modport master (
    output i_valid, i_op, i_argA, i_argB, i_ready, i_sticky_clr,
    input  o_ready, o_valid, o_result, o_status, o_sticky
  );
  modport slave (
    input  i_valid, i_op, i_argA, i_argB, i_ready, i_sticky_clr,
    output o_ready, o_valid, o_result, o_status, o_sticky
  );
`else
  modport master (
    output i_valid, i_op, i_argA, i_argB, i_ready,
    input  o_ready, o_valid, o_result, o_status
  );
  modport slave (
    input  i_valid, i_op, i_argA, i_argB, i_ready,
    output o_ready, o_valid, o_result, o_status
  );
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// Single-issue sequencer for sub / less-than / clear-bit / ZM->U2 on sign-magnitude operands.
// Latency: accept at edge k, o_valid high after edge k+2; no command accepted until the result is taken.
// Backpressure: result/status held stable while o_valid & !i_ready. Optional ALU_SEQ_STICKY_EN adds o_sticky.
module alu_op_sequencer #(
  parameter int m = 4,
  parameter int n = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alu_op_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [n-1:0] op_sub = n'(0);
  localparam logic [n-1:0] op_lt  = n'(1);
  localparam logic [n-1:0] op_clr = n'(2);
  localparam logic [n-1:0] op_cvt = n'(3);
  localparam logic [m-1:0] one_m  = m'(1);
  localparam logic [m-1:0] m_lim  = m'(m);

  state_t       state_q, state_d;
  logic [n-1:0] op_q;
  logic [m-1:0] a_q, b_q;
  logic         rdy_q, vld_q;
  logic [m-1:0] res_q;
  logic [3:0]   sts_q;
  logic         accept, hsk;

  assign accept = (state_q == IDLE) && bus.i_valid && rdy_q;
  assign hsk    = vld_q && bus.i_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = DONE;
      DONE:    if (hsk) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand decomposition shared by all units
  logic         sa, sb;
  logic [m-2:0] ma, mb;
  logic [m-1:0] msum, ua, ub;

  assign sa   = a_q[m-1];
  assign sb   = b_q[m-1];
  assign ma   = a_q[m-2:0];
  assign mb   = b_q[m-2:0];
  assign msum = {1'b0, ma} + {1'b0, mb};
  assign ua   = sa ? (~{1'b0, ma} + one_m) : {1'b0, ma};
  assign ub   = sb ? (~{1'b0, mb} + one_m) : {1'b0, mb};

  logic [m-1:0] res;
  logic [3:0]   sts;
  logic         err;

  always_comb begin
    res = '0;
    err = 1'b0;
    case (op_q)
      op_sub: begin
        // Opposite signs add magnitudes; same signs subtract, zero comes out positive
        if (sa != sb) begin
          if (msum[m-1]) err = 1'b1;
          else           res = {sa, msum[m-2:0]};
        end else if (ma >= mb) begin
          res = {sa & (ma != mb), ma - mb};
        end else begin
          res = {~sa, mb - ma};
        end
      end
      op_lt:  res = {{(m-1){1'b0}}, ($signed(ua) < $signed(ub))};
      op_clr: begin
        if (b_q[m-1] || (b_q >= m_lim)) err = 1'b1;
        else                            res = a_q & ~(one_m << b_q);
      end
      op_cvt: begin
        if (sa && (ma == '0)) err = 1'b1;
        else                  res = ua;
      end
      default: err = 1'b1;
    endcase
    if (err) res = '0;
    sts = err ? 4'b0001
              : {&res, ~^res, res[m-1], (op_q == op_lt) && (res == '0)};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sts_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == IDLE);
      if (accept) begin
        op_q <= bus.i_op;
        a_q  <= bus.i_argA;
        b_q  <= bus.i_argB;
      end
      if (state_q == EXEC) begin
        res_q <= res;
        sts_q <= sts;
      end
      if (hsk)                    vld_q <= 1'b0;
      else if (state_q == DONE)   vld_q <= 1'b1;
    end
  end

  assign bus.o_ready  = rdy_q;
  assign bus.o_valid  = vld_q;
  assign bus.o_result = res_q;
  assign bus.o_status = sts_q;

`ifdef ALU_SEQ_STICKY_EN
  logic [3:0] sticky_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              sticky_q <= '0;
    else if (bus.i_sticky_clr) sticky_q <= '0;
    else if (hsk)              sticky_q <= sticky_q | sts_q;
  end

  assign bus.o_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer (m=4, n=2) with hand-computed expectations.
module tb_alu_op_sequencer;

  logic clk;
  logic rst_n;
  int   npass;
  int   ntotal;

  alu_op_sequencer_if #(.m(4), .n(2)) bus ();

  alu_op_sequencer #(.m(4), .n(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] eres, input logic [3:0] ests, input string tag);
    bus.i_op    = op;
    bus.i_argA  = a;
    bus.i_argB  = b;
    bus.i_valid = 1'b1;
    chk({tag, "_rdy_pre"}, bus.o_ready, 1);
    tick();
    bus.i_valid = 1'b0;
    chk({tag, "_rdy_exec"}, bus.o_ready, 0);
    chk({tag, "_vld_k0"}, bus.o_valid, 0);
    tick();
    chk({tag, "_vld_k1"}, bus.o_valid, 0);
    tick();
    chk({tag, "_vld_k2"}, bus.o_valid, 1);
    chk({tag, "_res"}, bus.o_result, eres);
    chk({tag, "_sts"}, bus.o_status, ests);
    tick();
    chk({tag, "_vld_drop"}, bus.o_valid, 0);
    chk({tag, "_rdy_back"}, bus.o_ready, 1);
  endtask

  initial begin
    npass        = 0;
    ntotal       = 0;
    rst_n        = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_op     = 2'b00;
    bus.i_argA   = 4'b0000;
    bus.i_argB   = 4'b0000;
    bus.i_ready  = 1'b1;
`ifdef ALU_SEQ_STICKY_EN
    bus.i_sticky_clr = 1'b0;
`endif
    #12;
    chk("rst_ready", bus.o_ready, 0);
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_result", bus.o_result, 0);
    chk("rst_status", bus.o_status, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_ready_preclk", bus.o_ready, 0);
    tick();
    chk("rel_ready_postclk", bus.o_ready, 1);

    run(2'b00, 4'b0011, 4'b0101, 4'b1010, 4'b0110, "sub_3m5");
    run(2'b00, 4'b0111, 4'b1001, 4'b0000, 4'b0001, "sub_ovf");
    run(2'b00, 4'b1101, 4'b0010, 4'b1111, 4'b1110, "sub_max");
    run(2'b01, 4'b1010, 4'b0001, 4'b0001, 4'b0000, "lt_true");
    run(2'b01, 4'b0001, 4'b1010, 4'b0000, 4'b0101, "lt_false");
    run(2'b10, 4'b1111, 4'b0010, 4'b1011, 4'b0010, "clr_b2");
    run(2'b10, 4'b1111, 4'b0100, 4'b0000, 4'b0001, "clr_b4");
    run(2'b10, 4'b0110, 4'b1001, 4'b0000, 4'b0001, "clr_bneg");
    run(2'b11, 4'b1000, 4'b0000, 4'b0000, 4'b0001, "cvt_negz");
    run(2'b11, 4'b0101, 4'b0000, 4'b0101, 4'b0100, "cvt_pos");

    // Back-pressure with a new command waiting at the input
    bus.i_ready = 1'b0;
    bus.i_op    = 2'b11;
    bus.i_argA  = 4'b1011;
    bus.i_argB  = 4'b0000;
    bus.i_valid = 1'b1;
    tick();
    bus.i_op    = 2'b00;
    bus.i_argA  = 4'b0011;
    bus.i_argB  = 4'b0101;
    tick();
    tick();
    chk("bp_vld", bus.o_valid, 1);
    chk("bp_res", bus.o_result, 4'b1101);
    chk("bp_sts", bus.o_status, 4'b0010);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_vld", bus.o_valid, 1);
      chk("bp_hold_rdy", bus.o_ready, 0);
      chk("bp_hold_res", bus.o_result, 4'b1101);
      chk("bp_hold_sts", bus.o_status, 4'b0010);
    end
    bus.i_ready = 1'b1;
    tick();
    chk("bp_rel_vld", bus.o_valid, 0);
    chk("bp_rel_rdy", bus.o_ready, 1);
    chk("bp_rel_res", bus.o_result, 4'b1101);

    // Waiting command is accepted now, then aborted by reset during EXEC
    tick();
    bus.i_valid = 1'b0;
    chk("abort_exec_rdy", bus.o_ready, 0);
    rst_n = 1'b0;
    #2;
    chk("abort_vld", bus.o_valid, 0);
    chk("abort_rdy", bus.o_ready, 0);
    chk("abort_res", bus.o_result, 0);
    chk("abort_sts", bus.o_status, 0);
    rst_n = 1'b1;
    tick();
    chk("abort_idle_rdy", bus.o_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_vld", bus.o_valid, 0);
      chk("abort_no_res", bus.o_result, 0);
    end

`ifdef ALU_SEQ_STICKY_EN
    chk("sticky_rst", bus.o_sticky, 0);
    run(2'b10, 4'b1111, 4'b0100, 4'b0000, 4'b0001, "stk_err");
    run(2'b10, 4'b1111, 4'b0010, 4'b1011, 4'b0010, "stk_sign");
    chk("sticky_or", bus.o_sticky, 4'b0011);
    bus.i_sticky_clr = 1'b1;
    tick();
    bus.i_sticky_clr = 1'b0;
    chk("sticky_clr", bus.o_sticky, 0);
`endif

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
